// File: rtl/counter_pkg.sv
// Shared constants for the modulo counter: direction and boundary-mode encodings.
package counter_pkg;

    // Count direction as seen on the 'up' input.
    typedef enum logic {
        DIR_DN = 1'b0,
        DIR_UP = 1'b1
    } dir_e;

    // Boundary behaviour as seen on the 'sat' input.
    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

endpackage : counter_pkg

// File: rtl/counter_modn_if.sv
// Control/status bundle for counter_modn. The master drives the controls and
// observes the count; the slave (the counter) does the reverse. There is no
// valid/ready pair: every rising edge of clk is a transaction, so the controls
// are sampled on each edge and cnt/tc/ovf/unf are valid after each edge.
interface counter_modn_if #(
    parameter int N = 4
);
    logic         clr;
    logic         ld;
    logic [N-1:0] ld_val;
    logic         en;
    logic         up;
    logic         sat;
    logic [N-1:0] cnt;
    logic         tc;
    logic         ovf;
    logic         unf;

    modport master (
        output clr, ld, ld_val, en, up, sat,
        input  cnt, tc, ovf, unf
    );

    modport slave (
        input  clr, ld, ld_val, en, up, sat,
        output cnt, tc, ovf, unf
    );
endinterface : counter_modn_if

// File: rtl/counter_modn.sv
// Up/down modulo-(MAX+1) counter with clear, load, wrap/saturate boundary
// modes, registered overflow/underflow pulses and a combinational
// terminal-count flag. Priority on each edge: rst_n low > clr > ld > en.
module counter_modn
    import counter_pkg::*;
#(
    parameter int N   = 4,
    parameter int MAX = 2**N - 1
) (
    input  logic           clk,
    input  logic           rst_n,
    counter_modn_if.slave  bus
);

    // Comparisons against MAX are done one bit wider so MAX never truncates.
    localparam logic [N:0] MAX_W = (N+1)'(MAX);
    localparam logic [N:0] ONE_W = (N+1)'(1);

    logic [N-1:0] cnt_q;
    logic [N-1:0] cnt_d;
    logic         ovf_q;
    logic         ovf_d;
    logic         unf_q;
    logic         unf_d;
    logic [N:0]   cnt_ext;
    logic [N:0]   ld_ext;

    assign cnt_ext = {1'b0, cnt_q};
    assign ld_ext  = {1'b0, bus.ld_val};

    // Next-state: clear, clamped load, or enabled count with boundary handling.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (bus.clr) begin
            cnt_d = '0;
        end else if (bus.ld) begin
            cnt_d = (ld_ext > MAX_W) ? MAX_W[N-1:0] : bus.ld_val;
        end else if (bus.en) begin
            if (bus.up == DIR_UP) begin
                if (cnt_ext >= MAX_W) begin
                    ovf_d = 1'b1;
                    cnt_d = (bus.sat == MODE_SAT) ? MAX_W[N-1:0] : '0;
                end else begin
                    cnt_d = N'(cnt_ext + ONE_W);
                end
            end else begin
                if (cnt_ext == '0) begin
                    unf_d = 1'b1;
                    cnt_d = (bus.sat == MODE_SAT) ? '0 : MAX_W[N-1:0];
                end else begin
                    cnt_d = N'(cnt_ext - ONE_W);
                end
            end
        end
    end

    // State register with synchronous active-low reset overriding all controls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.cnt = cnt_q;
    assign bus.ovf = ovf_q;
    assign bus.unf = unf_q;
    // Terminal count tracks the current direction against the registered count.
    assign bus.tc  = (bus.up == DIR_UP) ? (cnt_ext == MAX_W) : (cnt_ext == '0);

endmodule : counter_modn

// File: tb/tb_counter_modn.sv
// Bench for counter_modn: one instance with MAX=9, one with the default MAX=15.
// Directed vectors carry hand-computed expectations; a random phase on the
// MAX=9 instance uses a small reference model. Expectations go into a queue
// at drive time and a monitor pops and compares one entry after each edge.
module tb_counter_modn;

    localparam int N     = 4;
    localparam int MAX_A = 9;
    localparam int MAX_B = 15;

    logic clk;
    logic rst_n;

    counter_modn_if #(.N(N)) bus_a ();
    counter_modn_if #(.N(N)) bus_b ();

    counter_modn #(.N(N), .MAX(MAX_A)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    counter_modn #(.N(N)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    // Entry: {sel, tc, ovf, unf, cnt[3:0]}; sel=0 checks dut_a, sel=1 dut_b.
    logic [7:0] exp_q[$];
    int tests_run = 0;
    int tests_failed = 0;
    logic [3:0] m_cnt;

    // Clock/reset block.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver: apply one vector on the falling edge and queue its expectation.
    task automatic drive(input logic sel, input logic r, input logic c, input logic l,
                         input logic [3:0] lv, input logic e, input logic u, input logic s,
                         input logic [3:0] ec, input logic eo, input logic eu, input logic et);
        @(negedge clk);
        rst_n = r;
        bus_a.clr = c; bus_a.ld = l; bus_a.ld_val = lv; bus_a.en = e; bus_a.up = u; bus_a.sat = s;
        bus_b.clr = c; bus_b.ld = l; bus_b.ld_val = lv; bus_b.en = e; bus_b.up = u; bus_b.sat = s;
        exp_q.push_back({sel, et, eo, eu, ec});
    endtask

    // Reference model step for the MAX=9 instance: returns {ovf, unf, cnt}.
    function automatic logic [5:0] model_step(input logic [3:0] cur, input logic r, input logic c,
                                              input logic l, input logic [3:0] lv, input logic e,
                                              input logic u, input logic s);
        int v;
        logic o;
        logic un;
        v = int'(cur); o = 1'b0; un = 1'b0;
        if (!r)      v = 0;
        else if (c)  v = 0;
        else if (l)  v = (int'(lv) > MAX_A) ? MAX_A : int'(lv);
        else if (e) begin
            if (u) begin
                if (v == MAX_A) begin o = 1'b1; v = s ? MAX_A : 0; end
                else v = v + 1;
            end else begin
                if (v == 0) begin un = 1'b1; v = s ? 0 : MAX_A; end
                else v = v - 1;
            end
        end
        return {o, un, v[3:0]};
    endfunction

    // Random driver: stimulus from $urandom_range, expectation from the model.
    task automatic drive_random();
        logic r, c, l, e, u, s;
        logic [3:0] lv;
        logic [5:0] nx;
        logic et;
        r  = ($urandom_range(0, 49) != 0);
        c  = ($urandom_range(0, 19) == 0);
        l  = ($urandom_range(0, 9) == 0);
        lv = 4'($urandom_range(0, 15));
        e  = ($urandom_range(0, 3) != 0);
        u  = 1'($urandom_range(0, 1));
        s  = 1'($urandom_range(0, 1));
        nx = model_step(m_cnt, r, c, l, lv, e, u, s);
        m_cnt = nx[3:0];
        et = u ? (int'(m_cnt) == MAX_A) : (m_cnt == 4'd0);
        drive(1'b0, r, c, l, lv, e, u, s, nx[3:0], nx[5], nx[4], et);
    endtask

    // Monitor/scoreboard: after each rising edge compare the selected DUT.
    initial begin
        logic [7:0] e;
        logic [6:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = e[7] ? {bus_b.tc, bus_b.ovf, bus_b.unf, bus_b.cnt}
                           : {bus_a.tc, bus_a.ovf, bus_a.unf, bus_a.cnt};
                tests_run++;
                if (act !== e[6:0]) begin
                    tests_failed++;
                    $display("FAIL dut_%s out: got tc=%b ovf=%b unf=%b cnt=%0d, expected tc=%b ovf=%b unf=%b cnt=%0d",
                             e[7] ? "b" : "a", act[6], act[5], act[4], act[3:0], e[6], e[5], e[4], e[3:0]);
                end
                tests_run++;
                if (int'(bus_a.cnt) > MAX_A || (bus_a.ovf && bus_a.unf)) begin
                    tests_failed++;
                    $display("FAIL dut_a range: got cnt=%0d ovf=%b unf=%b, expected cnt<=%0d and not both pulses",
                             bus_a.cnt, bus_a.ovf, bus_a.unf, MAX_A);
                end
            end
        end
    end

    // Stimulus sequence and final report.
    initial begin
        rst_n = 1'b0;
        bus_a.clr = 0; bus_a.ld = 0; bus_a.ld_val = 0; bus_a.en = 0; bus_a.up = 1; bus_a.sat = 0;
        bus_b.clr = 0; bus_b.ld = 0; bus_b.ld_val = 0; bus_b.en = 0; bus_b.up = 1; bus_b.sat = 0;

        //    sel r  c  l  lv  e  u  s  cnt ovf unf tc
        // Reset, then count up with wrap through 9 -> 0.
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 9; i++)
            drive(0, 1, 0, 0, 0, 1, 1, 0, 4'(i), 0, 0, (i == 9));
        drive(0, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 1, 1, 0, 2, 0, 0, 0);
        // Clear, then saturating down at 0 for three edges.
        drive(0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1, 1);
        drive(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1, 1);
        drive(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1, 1);
        // Wrap down from 0 to 9, then saturating up holds 9 with ovf.
        drive(0, 1, 0, 0, 0, 1, 0, 0, 9, 0, 1, 0);
        drive(0, 1, 0, 0, 0, 1, 1, 1, 9, 1, 0, 1);
        // Load clamp, clear over load, load over enable.
        drive(0, 1, 0, 1, 13, 0, 1, 0, 9, 0, 0, 1);
        drive(0, 1, 1, 1, 13, 0, 1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 4, 1, 1, 0, 4, 0, 0, 0);
        drive(0, 1, 0, 0, 4, 0, 1, 0, 4, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 1, 0, 0, 3, 0, 0, 0);
        // Reset mid-count overrides load and enable; counting resumes from 0.
        drive(0, 1, 0, 1, 5, 0, 1, 0, 5, 0, 0, 0);
        drive(0, 0, 0, 1, 7, 1, 1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        // Exact-MAX load and direction change while holding.
        drive(0, 1, 0, 1, 9, 0, 0, 0, 9, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 1, 0, 9, 0, 0, 1);
        drive(0, 1, 0, 1, 15, 0, 1, 0, 9, 0, 0, 1);

        // Default MAX=15 instance.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 1, 0, 0, 0, 1, 0, 0, 15, 0, 1, 0);
        drive(1, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0);
        drive(1, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        drive(1, 1, 0, 1, 15, 0, 1, 0, 15, 0, 0, 1);
        drive(1, 1, 0, 0, 0, 1, 1, 1, 15, 1, 0, 1);
        drive(1, 1, 0, 0, 0, 1, 0, 1, 14, 0, 0, 0);

        // Random phase on the MAX=9 instance, starting from reset.
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        m_cnt = 4'd0;
        for (int i = 0; i < 1000; i++)
            drive_random();

        repeat (3) @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_counter_modn
